// File: rtl/shared_reg_pkg.sv
// Shared types for the shared-register arbiter: per-requester op codes and FSM states.
// LOCKED exists only when SHARED_REG_LOCK_EN is defined.
package shared_reg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_NOP   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1
`ifdef SHARED_REG_LOCK_EN
        ,
        LOCKED = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot select of the first set req at or
// after ptr, searching circularly, plus a valid flag when any req is set.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          valid
);

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[(int'(ptr) + i) % N]) begin
                pick[(int'(ptr) + i) % N] = 1'b1;
                valid                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arb.sv
// Round-robin arbiter and write controller owning a shared W-bit flag register.
// Define SHARED_REG_LOCK_EN to add the lock port, LOCKED state and run counter.
module shared_reg_arb
    import shared_reg_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8
`ifdef SHARED_REG_LOCK_EN
    ,
    parameter int MAX_LOCK = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [2*N-1:0] op,
    input  logic [W*N-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
    input  logic [N-1:0]   lock,
`endif
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           upd
);

    localparam int PW = $clog2(N);

    state_t        state, state_n;
    logic [PW-1:0] ptr, ptr_n, owner, owner_inc, pick_ptr;
    logic [N-1:0]  gnt_n, pick;
    logic          pick_valid, hold_owner;
    logic [W-1:0]  q_n;
    logic          upd_n;
    op_t           owner_op;

    always_comb begin
        owner = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) owner = PW'(i);
        end
    end

    assign owner_inc = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
    // While a grant is closing, the next owner is searched from just past it.
    assign pick_ptr  = (state == IDLE) ? ptr : owner_inc;
    assign owner_op  = op_t'(op[int'(owner)*2 +: 2]);

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

`ifdef SHARED_REG_LOCK_EN
    localparam int RW = $clog2(MAX_LOCK + 1);
    logic [RW-1:0] run_cnt, run_n;

    assign hold_owner = lock[owner] && req[owner] && (run_cnt < RW'(MAX_LOCK));

    // Counts consecutive grants to the upcoming owner; restarts on owner change.
    always_comb begin
        run_n = '0;
        if (gnt_n != '0) begin
            if (gnt_n == gnt)
                run_n = (run_cnt == RW'(MAX_LOCK)) ? run_cnt : run_cnt + RW'(1);
            else
                run_n = RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) run_cnt <= '0;
        else      run_cnt <= run_n;
    end
`else
    assign hold_owner = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_n   = pick;
                    state_n = GRANT;
                end
            end
            default: begin
                if (!hold_owner) begin
                    ptr_n = owner_inc;
                    if (pick_valid) begin
                        gnt_n   = pick;
                        state_n = GRANT;
                    end else begin
                        gnt_n   = '0;
                        state_n = IDLE;
                    end
                end
`ifdef SHARED_REG_LOCK_EN
                else begin
                    state_n = LOCKED;
                end
`endif
            end
        endcase
    end

    always_comb begin
        q_n   = q;
        upd_n = 1'b0;
        if (state != IDLE) begin
            case (owner_op)
                OP_WRITE: q_n = wdata[int'(owner)*W +: W];
                OP_SET:   q_n = '1;
                OP_CLR:   q_n = '0;
                default:  q_n = q;
            endcase
            upd_n = (owner_op != OP_NOP);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
            q     <= '0;
            upd   <= 1'b0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            ptr   <= ptr_n;
            q     <= q_n;
            upd   <= upd_n;
        end
    end

endmodule
